// File: rtl/sequenciador_pc_busca.sv
// PC sequencer and fetch unit: holds the architectural PC, fetches over req/ack,
// hands instructions to decode over valid/stall and squashes wrong-path fetches.
module sequenciador_pc_busca #(
  parameter logic [31:0] ENDERECO_INICIAL = 32'h0000_0000,
  parameter int unsigned INCREMENTO       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] endereco_jump,
  input  logic        tomar_jump,
  output logic        busca_req,
  output logic [31:0] busca_endereco,
  input  logic        busca_ack,
  input  logic [31:0] instrucao_in,
  output logic [31:0] instrucao_out,
  output logic        instrucao_valida,
  input  logic        parar,
  output logic [31:0] endereco_PC
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    BUSCA    = 2'd1,
    ENTREGA  = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

  estado_t        estado;
  estado_t        proximo;

  logic [W-1:0]   alvo;
  logic [W-1:0]   pc_inc;
  logic [W-1:0]   pc_d;
  logic [W-1:0]   endereco_d;
  logic [W-1:0]   instrucao_d;
  logic           req_d;
  logic           valida_d;

  assign alvo   = {endereco_jump[W-1:2], 2'b00};
  assign pc_inc = endereco_PC + W'(INCREMENTO);

  // state register
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIO;
    else        estado <= proximo;
  end

  // next-state logic; a redirect always wins over ack and stall
  always_comb begin
    proximo = estado;
    case (estado)
      INICIO:   proximo = BUSCA;
      BUSCA: begin
        if (busca_ack)       proximo = tomar_jump ? INICIO : ENTREGA;
        else if (tomar_jump) proximo = DESCARTE;
      end
      ENTREGA: begin
        if (tomar_jump)  proximo = INICIO;
        else if (!parar) proximo = BUSCA;
      end
      DESCARTE: begin
        if (busca_ack) proximo = INICIO;
      end
      default:  proximo = INICIO;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    pc_d        = tomar_jump ? alvo : endereco_PC;
    req_d       = busca_req;
    endereco_d  = busca_endereco;
    instrucao_d = instrucao_out;
    valida_d    = instrucao_valida;
    case (estado)
      INICIO: begin
        req_d      = 1'b1;
        endereco_d = pc_d;
      end
      BUSCA: begin
        if (busca_ack) begin
          req_d = 1'b0;
          if (!tomar_jump) begin
            instrucao_d = instrucao_in;
            valida_d    = 1'b1;
            pc_d        = pc_inc;
          end
        end
      end
      ENTREGA: begin
        if (tomar_jump) begin
          valida_d = 1'b0;
        end else if (!parar) begin
          valida_d   = 1'b0;
          req_d      = 1'b1;
          endereco_d = endereco_PC;
        end
      end
      DESCARTE: begin
        // outstanding wrong-path fetch: wait for its ack and drop the data
        if (busca_ack) req_d = 1'b0;
      end
      default: ;
    endcase
  end

  // output / datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco_PC      <= ENDERECO_INICIAL;
      busca_req        <= 1'b0;
      busca_endereco   <= '0;
      instrucao_out    <= '0;
      instrucao_valida <= 1'b0;
    end else begin
      endereco_PC      <= pc_d;
      busca_req        <= req_d;
      busca_endereco   <= endereco_d;
      instrucao_out    <= instrucao_d;
      instrucao_valida <= valida_d;
    end
  end

endmodule

// File: tb/tb_sequenciador_pc_busca.sv
// Scoreboard bench for sequenciador_pc_busca: directed scenarios then random traffic,
// checked against a transaction-level model of fetch/deliver/squash.
module tb_sequenciador_pc_busca;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] endereco_jump = '0;
  logic        tomar_jump = 1'b0;
  logic        busca_req;
  logic [31:0] busca_endereco;
  logic        busca_ack = 1'b0;
  logic [31:0] instrucao_in = '0;
  logic [31:0] instrucao_out;
  logic        instrucao_valida;
  logic        parar = 1'b0;
  logic [31:0] endereco_PC;

  sequenciador_pc_busca dut (
    .clock            (clock),
    .reset            (reset),
    .endereco_jump    (endereco_jump),
    .tomar_jump       (tomar_jump),
    .busca_req        (busca_req),
    .busca_endereco   (busca_endereco),
    .busca_ack        (busca_ack),
    .instrucao_in     (instrucao_in),
    .instrucao_out    (instrucao_out),
    .instrucao_valida (instrucao_valida),
    .parar            (parar),
    .endereco_PC      (endereco_PC)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model: PC, one fetch in flight (maybe poisoned), one held instruction
  logic [31:0] m_pc = '0, m_addr = '0, m_out = '0;
  logic        m_req = 1'b0, m_valid = 1'b0, m_idle = 1'b1, m_drop = 1'b0;
  logic [31:0] q_instr[$];
  logic [31:0] q_fetch[$];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] npc;
    if (!reset) begin
      m_pc = '0; m_addr = '0; m_out = '0;
      m_req = 1'b0; m_valid = 1'b0; m_idle = 1'b1; m_drop = 1'b0;
      q_instr.delete();
      q_fetch.delete();
      return;
    end
    npc = tomar_jump ? {endereco_jump[31:2], 2'b00} : m_pc;
    if (m_idle) begin
      m_idle = 1'b0; m_drop = 1'b0; m_req = 1'b1; m_addr = npc;
      q_fetch.push_back(npc);
    end else if (m_req) begin
      if (busca_ack) begin
        m_req = 1'b0;
        if (m_drop || tomar_jump) m_idle = 1'b1;
        else begin
          m_valid = 1'b1;
          m_out   = m_addr ^ K;
          q_instr.push_back(m_addr ^ K);
          npc = m_pc + 32'd4;
        end
      end else if (tomar_jump) m_drop = 1'b1;
    end else if (m_valid) begin
      if (tomar_jump) begin
        m_valid = 1'b0; m_idle = 1'b1;
      end else if (!parar) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
        q_fetch.push_back(m_pc);
      end
    end
    m_pc = npc;
  endtask

  // one clock: drive inputs, advance model on the edge, compare on the falling edge
  task automatic cyc(input logic r, input logic tj, input logic [31:0] tgt,
                     input logic a, input logic p);
    reset = r; tomar_jump = tj; endereco_jump = tgt; busca_ack = a; parar = p;
    instrucao_in = a ? (busca_endereco ^ K) : 32'($urandom);
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("pc",     endereco_PC,              m_pc);
    chk("req",    32'(busca_req),           32'(m_req));
    chk("addr",   busca_endereco,           m_addr);
    chk("valida", 32'(instrucao_valida),    32'(m_valid));
    chk("out",    instrucao_out,            m_out);
  endtask

  // scoreboard monitor: each new delivery / new request pops one expectation
  logic v_prev = 1'b0, r_prev = 1'b0;
  always @(negedge clock) begin
    if (instrucao_valida && !v_prev) begin
      if (q_instr.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL instr_sb: got delivery %h expected none", instrucao_out);
      end else chk("instr_sb", instrucao_out, q_instr.pop_front());
    end
    if (busca_req && !r_prev) begin
      if (q_fetch.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL fetch_sb: got request %h expected none", busca_endereco);
      end else chk("fetch_sb", busca_endereco, q_fetch.pop_front());
    end
    v_prev = instrucao_valida;
    r_prev = busca_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    // T1 reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("t1_pc", endereco_PC, 32'h0);
    chk("t1_req", 32'(busca_req), 32'd0);
    chk("t1_valida", 32'(instrucao_valida), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t1_req1", 32'(busca_req), 32'd1);
    chk("t1_addr", busca_endereco, 32'h0);
    // T2 sequential fetch of 0,4,8,C
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      chk("t2_out", instrucao_out, (32'(i) * 32'd4) ^ K);
      if (i == 3) chk("t2_pc", endereco_PC, 32'h10);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    // T3 stall holds the instruction and blocks fetch
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("t3_hold", instrucao_out, 32'h10 ^ K);
      chk("t3_req", 32'(busca_req), 32'd0);
    end
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t3_next", busca_endereco, 32'h14);
    // T4 redirect with a fetch in flight at 0x8
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    chk("t4_addr8", busca_endereco, 32'h8);
    cyc(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
    chk("t4_held", busca_endereco, 32'h8);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t4_drop", 32'(instrucao_valida), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t4_target", busca_endereco, 32'h100);
    // T5 redirect beats stall
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
    chk("t5_squash", 32'(instrucao_valida), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t5_target", busca_endereco, 32'h40);
    // T6 PC wrap, then reset in the middle of a discard
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t6_addr", busca_endereco, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_wrap", endereco_PC, 32'h0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("t6_rst_pc", endereco_PC, 32'h0);
    chk("t6_rst_req", 32'(busca_req), 32'd0);
    chk("t6_rst_addr", busca_endereco, 32'h0);
    chk("t6_rst_out", instrucao_out, 32'h0);
    chk("t6_rst_valida", 32'(instrucao_valida), 32'd0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, tj, a, p;
      r  = ($urandom_range(0, 299) != 0);
      tj = ($urandom_range(0, 7) == 0);
      a  = m_req && ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 2) == 0);
      cyc(r, tj, 32'($urandom), a, p);
    end
    #2;
    chk("instr_q_empty", 32'(q_instr.size()), 32'd0);
    chk("fetch_q_empty", 32'(q_fetch.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
